// File: rtl/ins_fetch_pkg.sv
// Shared widths, opcode/quadrant codes, FSM states and small helpers for the fetch unit.
package ins_fetch_pkg;

  localparam int DAT_W     = 32;
  localparam int RAM_ADR_W = 32;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] CQ1 = 2'b01;
  localparam logic [1:0] CQ2 = 2'b10;

  localparam logic [2:0] C1_JAL  = 3'b001;
  localparam logic [2:0] C1_J    = 3'b101;
  localparam logic [2:0] C1_BEQZ = 3'b110;
  localparam logic [2:0] C1_BNEZ = 3'b111;
  localparam logic [2:0] C2_JR   = 3'b100;

  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_HOLD, ST_DROP} fetch_st_e;

  typedef struct packed {
    logic                 ic;
    logic [DAT_W-1:0]     ins;
    logic                 pbr;
    logic [RAM_ADR_W-1:0] npc;
  } dec_t;

  function automatic logic [1:0] sat2(input logic [1:0] c, input logic tk);
    if (tk) return (c == 2'b11) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/ins_fetch_bht.sv
// Branch history table: 2-bit saturating counters with one lookup and one update port.
module ins_fetch_bht
  import ins_fetch_pkg::*;
#(
  parameter int BHT_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic [BHT_BITS-1:0] rd_idx_i,
  output logic                rd_tk_o,
  input  logic                upd_i,
  input  logic [BHT_BITS-1:0] upd_idx_i,
  input  logic                upd_tk_i
);

  localparam int NENT = 1 << BHT_BITS;

  logic [NENT-1:0][1:0] cnt_q, cnt_d;

  for (genvar i = 0; i < NENT; i++) begin : g_ent
    assign cnt_d[i] = (en_i && upd_i && upd_idx_i == BHT_BITS'(i))
                      ? sat2(cnt_q[i], upd_tk_i) : cnt_q[i];
  end

  // Lookup reads the registered array, so a same-cycle update is not visible yet.
  assign rd_tk_o = cnt_q[rd_idx_i][1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= {NENT{2'b01}};
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch: PC sequencing, icache handshake, RV32I/RV32C length decode,
// local redirect on direct jumps and BHT-predicted branches.
module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter int                   BHT_BITS = 6,
  parameter logic [RAM_ADR_W-1:0] RST_PC   = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 ic_req_o,
  output logic [RAM_ADR_W-1:0] ic_addr_o,
  input  logic                 ic_rdy_i,
  input  logic [DAT_W-1:0]     ic_data_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic [RAM_ADR_W-1:0] flush_pc_i,
  input  logic                 bht_upd_i,
  input  logic [RAM_ADR_W-1:0] bht_upd_pc_i,
  input  logic                 bht_upd_tk_i,
  output logic                 if_en_o,
  output logic                 if_ic_o,
  output logic [DAT_W-1:0]     if_ins_o,
  output logic [RAM_ADR_W-1:0] if_pc_o,
  output logic                 if_pbr_o
);

  fetch_st_e            state_q, state_d;
  logic [RAM_ADR_W-1:0] pc_q, pc_d;
  logic [DAT_W-1:0]     hold_q, hold_d;
  logic                 ic_req_q, ic_req_d;
  logic [RAM_ADR_W-1:0] ic_addr_q, ic_addr_d;
  logic                 if_en_q, if_en_d;
  logic                 if_ic_q, if_ic_d;
  logic [DAT_W-1:0]     if_ins_q, if_ins_d;
  logic [RAM_ADR_W-1:0] if_pc_q, if_pc_d;
  logic                 if_pbr_q, if_pbr_d;

  logic [DAT_W-1:0]     w, imm_j, imm_b, imm_cj, imm_cb;
  logic [RAM_ADR_W-1:0] pc_step;
  logic                 is_c, bht_tk, issue;
  dec_t                 dec;

  logic unused_upd_pc;
  assign unused_upd_pc = ^{bht_upd_pc_i[RAM_ADR_W-1:BHT_BITS+1], bht_upd_pc_i[0]};

  ins_fetch_bht #(.BHT_BITS(BHT_BITS)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .en_i     (en),
    .rd_idx_i (pc_q[BHT_BITS:1]),
    .rd_tk_o  (bht_tk),
    .upd_i    (bht_upd_i),
    .upd_idx_i(bht_upd_pc_i[BHT_BITS:1]),
    .upd_tk_i (bht_upd_tk_i)
  );

  // A word parked by a stall is decoded from the holding register on release.
  assign w       = (state_q == ST_HOLD) ? hold_q : ic_data_i;
  assign is_c    = (w[1:0] != 2'b11);
  assign pc_step = pc_q + (is_c ? RAM_ADR_W'(2) : RAM_ADR_W'(4));

  assign imm_j  = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
  assign imm_b  = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
  assign imm_cj = {{21{w[12]}}, w[8], w[10:9], w[6], w[7], w[2], w[11], w[5:3], 1'b0};
  assign imm_cb = {{24{w[12]}}, w[6:5], w[2], w[11:10], w[4:3], 1'b0};

  always_comb begin
    dec     = '0;
    dec.ic  = is_c;
    dec.ins = is_c ? {{(DAT_W-16){1'b0}}, w[15:0]} : w;
    dec.npc = pc_step;
    if (!is_c) begin
      case (w[6:0])
        OP_JAL:    dec.npc = pc_q + RAM_ADR_W'(imm_j);
        OP_BRANCH: if (bht_tk) begin
                     dec.npc = pc_q + RAM_ADR_W'(imm_b);
                     dec.pbr = 1'b1;
                   end
        OP_JALR:   dec.npc = pc_step;
        default:   dec.npc = pc_step;
      endcase
    end else begin
      case ({w[1:0], w[15:13]})
        {CQ1, C1_J}, {CQ1, C1_JAL}:     dec.npc = pc_q + RAM_ADR_W'(imm_cj);
        {CQ1, C1_BEQZ}, {CQ1, C1_BNEZ}: if (bht_tk) begin
                                          dec.npc = pc_q + RAM_ADR_W'(imm_cb);
                                          dec.pbr = 1'b1;
                                        end
        {CQ2, C2_JR}:                   dec.npc = pc_step;
        default:                        dec.npc = pc_step;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    ic_req_d  = ic_req_q;
    ic_addr_d = ic_addr_q;
    if_en_d   = 1'b0;
    if_ic_d   = if_ic_q;
    if_ins_d  = if_ins_q;
    if_pc_d   = if_pc_q;
    if_pbr_d  = if_pbr_q;
    issue     = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (flush_i) pc_d = flush_pc_i;
        else begin
          ic_req_d  = 1'b1;
          ic_addr_d = pc_q;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ic_rdy_i) ic_req_d = 1'b0;
        if (flush_i) begin
          pc_d    = flush_pc_i;
          state_d = ic_rdy_i ? ST_REQ : ST_DROP;
        end else if (ic_rdy_i) begin
          if (!stall_i) begin
            issue   = 1'b1;
            state_d = ST_REQ;
          end else begin
            hold_d  = ic_data_i;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (flush_i) begin
          pc_d    = flush_pc_i;
          state_d = ST_REQ;
        end else if (!stall_i) begin
          issue   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (flush_i) pc_d = flush_pc_i;
        if (ic_rdy_i) begin
          ic_req_d = 1'b0;
          state_d  = ST_REQ;
        end
      end
    endcase
    if (flush_i) hold_d = '0;
    if (issue) begin
      if_en_d  = 1'b1;
      if_ic_d  = dec.ic;
      if_ins_d = dec.ins;
      if_pc_d  = pc_q;
      if_pbr_d = dec.pbr;
      pc_d     = dec.npc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_REQ;
      pc_q      <= RST_PC;
      hold_q    <= '0;
      ic_req_q  <= 1'b0;
      ic_addr_q <= RST_PC;
      if_en_q   <= 1'b0;
      if_ic_q   <= 1'b0;
      if_ins_q  <= '0;
      if_pc_q   <= '0;
      if_pbr_q  <= 1'b0;
    end else if (en) begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      ic_req_q  <= ic_req_d;
      ic_addr_q <= ic_addr_d;
      if_en_q   <= if_en_d;
      if_ic_q   <= if_ic_d;
      if_ins_q  <= if_ins_d;
      if_pc_q   <= if_pc_d;
      if_pbr_q  <= if_pbr_d;
    end
  end

  assign ic_req_o  = ic_req_q;
  assign ic_addr_o = ic_addr_q;
  assign if_en_o   = if_en_q;
  assign if_ic_o   = if_ic_q;
  assign if_ins_o  = if_ins_q;
  assign if_pc_o   = if_pc_q;
  assign if_pbr_o  = if_pbr_q;

endmodule

// File: tb/tb_ins_fetch.sv
// Fetch unit bench: directed scenarios then randomized transactions against a
// transaction-level model (known instruction kind/immediate, BHT counter array).
module tb_ins_fetch;
  import ins_fetch_pkg::*;

  localparam int M_NORM = 0, M_STALL = 1, M_FWAIT = 2, M_FRDY = 3, M_FHOLD = 4;
  localparam int K_OTHER = 0, K_JUMP = 1, K_BR = 2;

  logic        clk, rst, en;
  logic        ic_req_o, ic_rdy_i, stall_i, flush_i;
  logic [31:0] ic_addr_o, ic_data_i, flush_pc_i, bht_upd_pc_i;
  logic        bht_upd_i, bht_upd_tk_i;
  logic        if_en_o, if_ic_o, if_pbr_o;
  logic [31:0] if_ins_o, if_pc_o;

  ins_fetch #(.BHT_BITS(6), .RST_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .en(en),
    .ic_req_o(ic_req_o), .ic_addr_o(ic_addr_o), .ic_rdy_i(ic_rdy_i), .ic_data_i(ic_data_i),
    .stall_i(stall_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .bht_upd_i(bht_upd_i), .bht_upd_pc_i(bht_upd_pc_i), .bht_upd_tk_i(bht_upd_tk_i),
    .if_en_o(if_en_o), .if_ic_o(if_ic_o), .if_ins_o(if_ins_o), .if_pc_o(if_pc_o),
    .if_pbr_o(if_pbr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  logic [1:0]  bht_m [64];
  logic [31:0] exp_pc;
  logic        en_exp, rnd_upd;
  logic        e_ic, e_pbr;
  logic [31:0] e_ins, e_npc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) bht_m[i] = 2'd1;
  endtask

  task automatic model_upd(input logic [31:0] pc, input logic tk);
    if (tk && bht_m[pc[6:1]] < 2'd3) bht_m[pc[6:1]] = bht_m[pc[6:1]] + 2'd1;
    else if (!tk && bht_m[pc[6:1]] > 2'd0) bht_m[pc[6:1]] = bht_m[pc[6:1]] - 2'd1;
  endtask

  // Inputs are driven at negedge, outputs sampled at the following negedge.
  task automatic tick();
    logic [31:0] r;
    if (rnd_upd && $urandom_range(0, 2) == 0) begin
      r = $urandom;
      bht_upd_i    = 1'b1;
      bht_upd_pc_i = ($urandom_range(0, 1) == 1) ? exp_pc : r;
      bht_upd_tk_i = r[7];
    end
    @(posedge clk);
    if (bht_upd_i && en && !rst) model_upd(bht_upd_pc_i, bht_upd_tk_i);
    @(negedge clk);
    chk("if_en", if_en_o, en_exp);
    ic_rdy_i  = 1'b0;
    flush_i   = 1'b0;
    bht_upd_i = 1'b0;
  endtask

  task automatic calc(input logic [31:0] w, input int knd, input logic [31:0] imm,
                      input logic [31:0] pc);
    e_ic  = (w[1:0] != 2'b11);
    e_ins = e_ic ? {16'h0, w[15:0]} : w;
    e_npc = pc + (e_ic ? 32'd2 : 32'd4);
    e_pbr = 1'b0;
    if (knd == K_JUMP) e_npc = pc + imm;
    if (knd == K_BR && bht_m[pc[6:1]][1]) begin
      e_npc = pc + imm;
      e_pbr = 1'b1;
    end
  endtask

  task automatic gen_ins(output logic [31:0] w, output int knd, output logic [31:0] imm);
    logic [31:0] r, r2, r3;
    logic [2:0]  f3;
    r = $urandom; r2 = $urandom; r3 = $urandom;
    knd = K_OTHER; imm = 32'h0;
    case ($urandom_range(0, 7))
      0: begin
        w = r3; w[1:0] = 2'b11;
        if (w[6:0] == 7'b1101111 || w[6:0] == 7'b1100111 || w[6:0] == 7'b1100011) w[6:0] = 7'h13;
      end
      1: begin
        w = r3; if (w[1:0] == 2'b11) w[1:0] = 2'b00;
        if ((w[1:0] == 2'b01 && (w[15:13] == 3'd1 || w[15:13] >= 3'd5)) ||
            (w[1:0] == 2'b10 && w[15:13] == 3'd4)) w[15:13] = 3'd0;
      end
      2: begin
        imm = {{11{r[20]}}, r[20:1], 1'b0}; knd = K_JUMP;
        w = {imm[20], imm[10:1], imm[11], imm[19:12], r2[11:7], 7'b1101111};
      end
      3: w = {r3[31:15], 3'b000, r3[11:7], 7'b1100111};
      4: begin
        imm = {{19{r[12]}}, r[12:1], 1'b0}; knd = K_BR;
        f3 = r2[2:0]; if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd0;
        w = {imm[12], imm[10:5], r2[12:3], f3, imm[4:1], imm[11], 7'b1100011};
      end
      5: begin
        imm = {{20{r[11]}}, r[11:1], 1'b0}; knd = K_JUMP;
        f3 = r2[0] ? 3'b101 : 3'b001;
        w = {r3[31:16], f3, imm[11], imm[4], imm[9:8], imm[10], imm[6], imm[7], imm[3:1], imm[5], 2'b01};
      end
      6: begin
        imm = {{23{r[8]}}, r[8:1], 1'b0}; knd = K_BR;
        f3 = r2[0] ? 3'b110 : 3'b111;
        w = {r3[31:16], f3, imm[8], imm[4:3], r2[3:1], imm[7:6], imm[2:1], imm[5], 2'b01};
      end
      default: w = {r3[31:16], 3'b100, r2[0], r2[5:1] | 5'd1, 5'd0, 2'b10};
    endcase
  endtask

  task automatic do_fetch(input int mode, input logic [31:0] w, input int knd,
                          input logic [31:0] imm, input logic [31:0] tgt, input int hold);
    logic [31:0] pc, r;
    for (int n = 0; n < 20 && !ic_req_o; n++) tick();
    if (!ic_req_o) begin
      chk("req_timeout", ic_req_o, 1);
      return;
    end
    chk("ic_addr", ic_addr_o, exp_pc);
    pc = exp_pc;
    repeat ($urandom_range(0, 2)) tick();
    case (mode)
      M_FWAIT: begin
        if ($urandom_range(0, 1) == 1) begin
          r = $urandom;
          flush_i = 1'b1; flush_pc_i = {r[31:1], 1'b0}; tick();
        end
        flush_i = 1'b1; flush_pc_i = tgt; tick();
        exp_pc = tgt;
        chk("drop_req", ic_req_o, 1);
        ic_rdy_i = 1'b1; ic_data_i = w; tick();
      end
      M_FRDY: begin
        ic_rdy_i = 1'b1; ic_data_i = w; flush_i = 1'b1; flush_pc_i = tgt;
        stall_i = 1'($urandom_range(0, 1));
        tick();
        stall_i = 1'b0;
        exp_pc = tgt;
      end
      M_NORM: begin
        ic_rdy_i = 1'b1; ic_data_i = w; stall_i = 1'b0;
        calc(w, knd, imm, pc);
        en_exp = 1'b1;
        tick();
        chk("if_ic", if_ic_o, e_ic);
        chk("if_ins", if_ins_o, e_ins);
        chk("if_pc", if_pc_o, pc);
        chk("if_pbr", if_pbr_o, e_pbr);
        exp_pc = e_npc;
        if (rnd_upd && $urandom_range(0, 7) == 0) begin
          en = 1'b0;
          tick(); tick();
          chk("frz_req", ic_req_o, 0);
          en = 1'b1;
        end
        en_exp = 1'b0;
      end
      default: begin
        ic_rdy_i = 1'b1; ic_data_i = w; stall_i = 1'b1;
        tick();
        r = $urandom; ic_data_i = r;
        repeat (hold - 1) tick();
        if (mode == M_FHOLD) begin
          flush_i = 1'b1; flush_pc_i = tgt; stall_i = 1'($urandom_range(0, 1));
          tick();
          stall_i = 1'b0;
          exp_pc = tgt;
        end else begin
          stall_i = 1'b0;
          calc(w, knd, imm, pc);
          en_exp = 1'b1;
          tick();
          en_exp = 1'b0;
          chk("hold_ic", if_ic_o, e_ic);
          chk("hold_ins", if_ins_o, e_ins);
          chk("hold_pc", if_pc_o, pc);
          chk("hold_pbr", if_pbr_o, e_pbr);
          exp_pc = e_npc;
          tick();
        end
      end
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [31:0] w, imm, r;
    int          knd, m;
    rst = 1'b1; en = 1'b1; ic_rdy_i = 1'b0; ic_data_i = 32'h0; stall_i = 1'b0;
    flush_i = 1'b0; flush_pc_i = 32'h0; bht_upd_i = 1'b0; bht_upd_pc_i = 32'h0;
    bht_upd_tk_i = 1'b0; en_exp = 1'b0; rnd_upd = 1'b0; exp_pc = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req", ic_req_o, 0);
    chk("rst_addr", ic_addr_o, 0);
    chk("rst_en", if_en_o, 0);
    chk("rst_ic", if_ic_o, 0);
    chk("rst_ins", if_ins_o, 0);
    chk("rst_pc", if_pc_o, 0);
    chk("rst_pbr", if_pbr_o, 0);
    rst = 1'b0;

    do_fetch(M_NORM, 32'h0050_0093, K_OTHER, 0, 0, 0);
    do_fetch(M_NORM, 32'h0001_4505, K_OTHER, 0, 0, 0);
    do_fetch(M_FRDY, 32'h0050_0093, K_OTHER, 0, 32'h8, 0);
    do_fetch(M_NORM, 32'h0100_006F, K_JUMP, 32'd16, 0, 0);
    do_fetch(M_FWAIT, 32'h0050_0093, K_OTHER, 0, 32'h20, 0);
    do_fetch(M_NORM, 32'h0000_BFF5, K_JUMP, 32'hFFFF_FFFC, 0, 0);
    do_fetch(M_FRDY, 32'h0050_0093, K_OTHER, 0, 32'h40, 0);
    do_fetch(M_NORM, 32'hFE00_0CE3, K_BR, 32'hFFFF_FFF8, 0, 0);
    repeat (2) begin
      bht_upd_i = 1'b1; bht_upd_pc_i = 32'h40; bht_upd_tk_i = 1'b1;
      tick();
    end
    do_fetch(M_FWAIT, 32'h0050_0093, K_OTHER, 0, 32'h40, 0);
    do_fetch(M_NORM, 32'hFE00_0CE3, K_BR, 32'hFFFF_FFF8, 0, 0);
    do_fetch(M_STALL, 32'h0050_0093, K_OTHER, 0, 0, 5);
    do_fetch(M_FWAIT, 32'h0050_0093, K_OTHER, 0, 32'h100, 0);
    do_fetch(M_FRDY, 32'h0050_0093, K_OTHER, 0, 32'h100, 0);
    do_fetch(M_FHOLD, 32'h0050_0093, K_OTHER, 0, 32'h200, 2);

    // Reset while a request is outstanding; a stray ready right after must be ignored.
    for (int n = 0; n < 20 && !ic_req_o; n++) tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", ic_req_o, 0);
    chk("mid_rst_addr", ic_addr_o, 0);
    @(negedge clk);
    rst = 1'b0; ic_rdy_i = 1'b1; ic_data_i = 32'h0050_0093;
    exp_pc = 32'h0;
    model_reset();
    tick();
    chk("post_rst_req", ic_req_o, 1);
    do_fetch(M_NORM, 32'h0001_4505, K_OTHER, 0, 0, 0);

    rnd_upd = 1'b1;
    for (int i = 0; i < 300; i++) begin
      gen_ins(w, knd, imm);
      r = $urandom;
      m = $urandom_range(0, 9);
      if (m <= 4) m = M_NORM;
      else if (m <= 6) m = M_STALL;
      else if (m == 7) m = M_FWAIT;
      else if (m == 8) m = M_FRDY;
      else m = M_FHOLD;
      do_fetch(m, w, knd, imm, {r[31:1], 1'b0}, $urandom_range(1, 4));
    end
    rnd_upd = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ins_fetch.md
# ins_fetch

Instruction fetch unit. It drives the PC, requests instruction words from the instruction cache, and classifies each word as RV32I or RV32C. It redirects locally on direct jumps, predicts conditional branches with a 2-bit BHT, and hands one instruction per issue to the decoder over the `if_*` bundle. It is the producer end of the fetch→decode interface; it sits between icache and decoder and takes redirects from the ROB.

## Interface
- `BHT_BITS`, 6: BHT index width, giving 2^BHT_BITS entries indexed by pc[BHT_BITS:1].
- `RST_PC`, 0: PC loaded at reset.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: global enable; low freezes all state, and outputs hold their values.
- `ic_req_o` out 1: fetch request, held high until accepted by `ic_rdy_i`.
- `ic_addr_o` out `RAM_ADR_W`: halfword-aligned fetch address.
- `ic_rdy_i` in 1: data valid, one-cycle pulse; a request is outstanding at most once.
- `ic_data_i` in `DAT_W`: 32 bits starting at `ic_addr_o`; the cache handles word straddle.
- `stall_i` in 1: ROB/RS full; the decoder must not receive an instruction.
- `flush_i` in 1: mispredict or jalr redirect from the ROB.
- `flush_pc_i` in `RAM_ADR_W`: redirect target.
- `bht_upd_i` in 1: branch commit update.
- `bht_upd_pc_i` in `RAM_ADR_W`: PC of the committed branch.
- `bht_upd_tk_i` in 1: actual outcome of the committed branch.
- `if_en_o` out 1: instruction valid, one-cycle pulse.
- `if_ic_o` out 1: 0 = RV32I, 1 = RV32C.
- `if_ins_o` out `DAT_W`: instruction; for RV32C, bits [31:16] are zero.
- `if_pc_o` out `RAM_ADR_W`: PC of the instruction.
- `if_pbr_o` out 1: predicted taken; meaningful only for conditional branches.

## Operation
- FSM states: REQ, WAIT, HOLD, DROP.
- REQ: drive `ic_req_o=1` with `ic_addr_o=pc`, then go to WAIT.
- WAIT: on `ic_rdy_i`, decode length and next PC.
  - If `stall_i=0`, latch the outputs, pulse `if_en_o`, update pc, go to REQ.
  - Otherwise latch the word into a holding register and go to HOLD.
- HOLD: wait until `stall_i=0`, then issue from the holding register, update pc, go to REQ.
- DROP: entered on `flush_i` while WAIT. Wait for `ic_rdy_i`, discard the data, go to REQ with the new pc.
- Length: `ic_data_i[1:0]!=2'b11` means compressed: `if_ic_o=1`, low 16 bits, step +2. Otherwise step +4.
- Next PC:
  - JAL: pc+J-imm. C.J and C.JAL (quadrant 01, funct3 101/001): pc+CJ-imm.
  - B-type, C.BEQZ, C.BNEZ: if BHT[idx][1], pc+B-imm (or CB-imm) with `if_pbr_o=1`; else pc+step with `if_pbr_o=0`.
  - JALR, C.JR, C.JALR: pc+step (the ROB redirects); `if_pbr_o=0`.
  - All other instructions: pc+step.
- Immediates are sign-extended to 32 bits; additions wrap modulo 2^`RAM_ADR_W`.
- BHT: 2-bit saturating counters, reset to 2'b01. On `bht_upd_i`, increment if taken (saturating at 3), else decrement (saturating at 0).
  - A same-cycle update and lookup of the same entry reads the old value.

## Timing
- Reset values: state=REQ, pc=`RST_PC`, `ic_req_o=0`, `ic_addr_o=RST_PC`, `if_en_o=0`, `if_ic_o=0`, `if_ins_o=0`, `if_pc_o=0`, `if_pbr_o=0`, BHT all 2'b01.
- Latency: `ic_rdy_i` at cycle t with no stall gives `if_en_o` high at t+1. Peak throughput is one instruction per 3 cycles with a 1-cycle cache.
- `flush_i` has top priority in every state:
  - pc←`flush_pc_i`; `if_en_o` is forced to 0 that cycle; the holding register is cleared.
  - From WAIT, go to DROP.
  - From REQ or HOLD, go to REQ.
  - In DROP, a second flush only updates pc.
- `ic_rdy_i` and `flush_i` in the same cycle: the data is discarded, and the next state is REQ (no DROP).
- `stall_i` rising in the same cycle as `ic_rdy_i`: go to HOLD, nothing issued.
- Reset mid-WAIT: the next `ic_rdy_i` is ignored unless a request is pending.

## Structure
- The shared head include holds:
  - `DAT_W`, `RAM_ADR_W`;
  - opcode constants (JAL 7'b1101111, JALR 7'b1100111, BRANCH 7'b1100011);
  - RV32C quadrant/funct3 codes;
  - state encodings.
- Sub-module `bht`: counter array with a lookup port and an update port, async reset.
- Next-PC/immediate extraction is combinational logic inside `ins_fetch`.

## Test plan
- Reset with `RST_PC`=0; cache returns 0x00500093 (addi) → `ic_addr_o`=0, `if_en_o` pulse with `if_ic_o=0`, `if_pc_o=0`, next `ic_addr_o`=4.
- Word 0x0001_4505 at pc 4 (c.li) → `if_ic_o=1`, `if_ins_o`=0x00004505, next addr 6.
- JAL 0x0100006F at pc 8 → issued with `if_pc_o=8`, next addr 0x18; C.J backward by 4 at 0x20 → next addr 0x1C.
- BEQ with imm −8 at 0x40, BHT entry reset → pbr=0, next addr 0x44. After two `bht_upd_tk_i=1` updates at 0x40, refetch → pbr=1, next addr 0x38.
- `stall_i` held 5 cycles across `ic_rdy_i` → no `if_en_o` during stall; exactly one pulse with the held word after release.
- `flush_i` to 0x100 while WAIT → that cycle's returning data is never issued; next request at 0x100. Simultaneous flush+`ic_rdy_i` → next request at 0x100 in the following cycle.
